// File: rtl/diff_pkg.sv
// Shared constants and state encoding for the DIFF mask index decoder.
package diff_pkg;

    localparam int unsigned WIDTH_D  = 32;
    localparam int unsigned NIBBLE_D = 4;
    localparam int unsigned IDX_W    = $clog2(WIDTH_D);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/diff_group_pe.sv
// Combinational priority encoder for one NIBBLE-wide slice of the mask:
// lowest set bit index, any bit set, and two-or-more bits set.
module diff_group_pe #(
    parameter int unsigned NIBBLE = 4,
    parameter int unsigned LW     = (NIBBLE > 1) ? $clog2(NIBBLE) : 1
) (
    input  logic [NIBBLE-1:0] bits,
    output logic [LW-1:0]     local_idx,
    output logic              any,
    output logic              many
);

    always_comb begin
        local_idx = '0;
        any       = 1'b0;
        many      = 1'b0;
        // Ascending scan: the first hit is the lowest bit, later hits flag many.
        for (int i = 0; i < int'(NIBBLE); i++) begin
            if (bits[i]) begin
                if (any) begin
                    many = 1'b1;
                end else begin
                    local_idx = LW'(i);
                    any       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/diff_index_decoder.sv
// Multi-cycle lowest-set-bit decoder for DIFF masks; scans one group per cycle
// for a fixed GROUPS cycles and flags empty or multi-bit masks.
module diff_index_decoder
    import diff_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_D,
    parameter int unsigned NIBBLE = NIBBLE_D
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH-1:0]         onehot_in,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     zero,
    output logic                     multi
);

    localparam int unsigned GROUPS = WIDTH / NIBBLE;
    localparam int unsigned IW     = $clog2(WIDTH);
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned LW     = (NIBBLE > 1) ? $clog2(NIBBLE) : 1;

    state_e                         state_q, state_d;
    logic [GROUPS-1:0][NIBBLE-1:0]  mask_q, mask_d;
    logic [GW-1:0]                  grp_q, grp_d;
    logic                           found_q, found_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic                           zero_q, zero_d;
    logic                           multi_q, multi_d;

    logic [NIBBLE-1:0]              grp_bits;
    logic [LW-1:0]                  g_idx;
    logic                           g_any;
    logic                           g_many;
    logic                           last_grp;
    logic [IW-1:0]                  grp_base;

    assign grp_bits = mask_q[grp_q];
    assign last_grp = (grp_q == GW'(GROUPS - 1));
    assign grp_base = IW'(grp_q) * IW'(NIBBLE);

    diff_group_pe #(
        .NIBBLE (NIBBLE),
        .LW     (LW)
    ) u_group_pe (
        .bits      (grp_bits),
        .local_idx (g_idx),
        .any       (g_any),
        .many      (g_many)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        grp_d   = grp_q;
        found_d = found_q;
        idx_d   = idx_q;
        zero_d  = zero_q;
        multi_d = multi_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SCAN;
                    mask_d  = onehot_in;
                    grp_d   = '0;
                    found_d = 1'b0;
                    idx_d   = '0;
                    zero_d  = 1'b0;
                    multi_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (g_any) begin
                    if (!found_q) begin
                        idx_d   = grp_base + IW'(g_idx);
                        found_d = 1'b1;
                    end else begin
                        multi_d = 1'b1;
                    end
                end
                if (g_many) begin
                    multi_d = 1'b1;
                end
                grp_d = grp_q + 1'b1;
                // No early exit: every group is visited so latency is data-independent.
                if (last_grp) begin
                    state_d = DONE;
                    zero_d  = ~(found_q | g_any);
                    grp_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            grp_q   <= '0;
            found_q <= 1'b0;
            idx_q   <= '0;
            zero_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            grp_q   <= grp_d;
            found_q <= found_d;
            idx_q   <= idx_d;
            zero_q  <= zero_d;
            multi_q <= multi_d;
        end
    end

    assign busy  = (state_q == SCAN);
    assign done  = (state_q == DONE);
    assign idx   = idx_q;
    assign zero  = zero_q;
    assign multi = multi_q;

endmodule

// File: tb/tb_diff_index_decoder.sv
// Randomized self-checking bench for diff_index_decoder against a lowest-bit model.
module tb_diff_index_decoder;
    import diff_pkg::*;

    localparam int unsigned WIDTH  = WIDTH_D;
    localparam int unsigned NIBBLE = NIBBLE_D;
    localparam int unsigned GROUPS = WIDTH / NIBBLE;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] onehot_in;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] idx;
    logic             zero;
    logic             multi;

    int n_vec = 0;
    int n_err = 0;

    diff_index_decoder #(
        .WIDTH  (WIDTH),
        .NIBBLE (NIBBLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .onehot_in (onehot_in),
        .busy      (busy),
        .done      (done),
        .idx       (idx),
        .zero      (zero),
        .multi     (multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_idx(input logic [WIDTH-1:0] m);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [WIDTH-1:0] rand_mask();
        logic [WIDTH-1:0] m;
        m = '0;
        case ($urandom_range(0, 3))
            0: m = '0;
            1: m[$urandom_range(0, WIDTH - 1)] = 1'b1;
            2: begin
                m[$urandom_range(0, WIDTH - 1)] = 1'b1;
                m[$urandom_range(0, WIDTH - 1)] = 1'b1;
            end
            default: m = $urandom;
        endcase
        return m;
    endfunction

    task automatic launch(input logic [WIDTH-1:0] m);
        @(negedge clk);
        start     = 1'b1;
        onehot_in = m;
    endtask

    // Follows one decode that was accepted at the last edge; optionally requests
    // the next decode in the DONE cycle.
    task automatic observe(input logic [WIDTH-1:0] m, input bit hold, input bit chain,
                           input logic [WIDTH-1:0] nxt);
        int  busy_cnt;
        bit  got;
        busy_cnt = 0;
        got      = 1'b0;
        for (int k = 1; k <= int'(GROUPS) + 4 && !got; k++) begin
            @(negedge clk);
            check("busy_and_done", 32'(busy & done), 32'd0);
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
                check("latency", 32'(k), 32'(GROUPS + 1));
                check("busy_cycles", 32'(busy_cnt), 32'(GROUPS));
                check("idx", 32'(idx), 32'(model_idx(m)));
                check("zero", 32'(zero), 32'(m == '0));
                check("multi", 32'(multi), 32'($countones(m) > 1));
                start     = chain;
                onehot_in = nxt;
            end else begin
                start     = hold;
                onehot_in = $urandom;
            end
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
            start = 1'b0;
        end
    endtask

    initial begin
        logic [WIDTH-1:0] dir [6];
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nxt;
        bit               ch;
        bit               saw_done;

        dir[0] = 32'h0000_0001;
        dir[1] = 32'h8000_0000;
        dir[2] = 32'h0000_0400;
        dir[3] = 32'h0000_0000;
        dir[4] = 32'h0001_0100;
        dir[5] = 32'h0000_0006;

        rst       = 1'b1;
        start     = 1'b0;
        onehot_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(idx), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_multi", 32'(multi), 32'd0);
        rst = 1'b0;

        foreach (dir[i]) begin
            launch(dir[i]);
            observe(dir[i], 1'b0, 1'b0, '0);
            @(negedge clk);
            check("idle_done_low", 32'(done), 32'd0);
            check("idle_idx_hold", 32'(idx), 32'(model_idx(dir[i])));
        end

        // start held through SCAN is ignored; start in DONE chains a second decode.
        launch(32'h0000_0100);
        observe(32'h0000_0100, 1'b1, 1'b1, 32'h0000_8000);
        observe(32'h0000_8000, 1'b0, 1'b0, '0);

        // Reset on the 4th SCAN cycle aborts the decode.
        launch(32'h0000_0004);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_idx", 32'(idx), 32'd0);
        check("abort_zero", 32'(zero), 32'd0);
        check("abort_multi", 32'(multi), 32'd0);
        saw_done = 1'b0;
        repeat (GROUPS + 4) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        launch(32'h0000_0020);
        observe(32'h0000_0020, 1'b0, 1'b0, '0);

        cur = rand_mask();
        launch(cur);
        for (int i = 0; i < 40; i++) begin
            nxt = rand_mask();
            ch  = 1'($urandom_range(0, 1));
            observe(cur, 1'($urandom_range(0, 1)), ch, nxt);
            if (!ch) begin
                @(negedge clk);
                check("rnd_idle_done", 32'(done), 32'd0);
                check("rnd_idle_busy", 32'(busy), 32'd0);
                check("rnd_hold_idx", 32'(idx), 32'(model_idx(cur)));
                start     = 1'b1;
                onehot_in = nxt;
            end
            cur = nxt;
        end
        observe(cur, 1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
